// File: rtl/fft_pkg.sv
// Shared types and helpers for the in-place radix-2 DIF FFT control path.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } fft_state_e;

    localparam int DEF_N_POINTS = 8;
    localparam int DEF_BF_LAT   = 2;

    // Stage-counter width: $clog2(LOG2_N), never narrower than one bit.
    function automatic int stage_w(input int log2n);
        return (log2n > 1) ? $clog2(log2n) : 1;
    endfunction

    // Twiddle index spans N/2 entries.
    function automatic int tw_w(input int log2n);
        return (log2n > 1) ? log2n - 1 : 1;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = v[w-1-i];
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly address/twiddle generator: (stage, k) -> upper/lower leg addresses and twiddle index.
module fft_addr_gen import fft_pkg::*; #(
    parameter int  LOG2_N = 3,
    localparam int SW     = stage_w(LOG2_N),
    localparam int TW     = tw_w(LOG2_N)
) (
    input  logic [SW-1:0]     stage,
    input  logic [LOG2_N-2:0] k,
    output logic [LOG2_N-1:0] addr_a,
    output logic [LOG2_N-1:0] addr_b,
    output logic [TW-1:0]     tw_idx
);

    logic [LOG2_N-1:0] span, mask, k_ext, j_off;

    // span is a power of two, so group/offset split is a mask and the
    // group*2*span term is just the high bits of k shifted up by one.
    always_comb begin
        span   = LOG2_N'(1) << (LOG2_N'(LOG2_N - 1) - LOG2_N'(stage));
        mask   = span - LOG2_N'(1);
        k_ext  = {1'b0, k};
        j_off  = k_ext & mask;
        addr_a = ((k_ext & ~mask) << 1) | j_off;
        addr_b = addr_a | span;
        tw_idx = TW'(j_off << stage);
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage sequencer for the in-place radix-2 DIF FFT: butterfly read/write-back
// scheduling per stage, then bit-reversed streaming of the result.
module fft_stage_sequencer import fft_pkg::*; #(
    parameter int  N_POINTS = DEF_N_POINTS,
    parameter int  LOG2_N   = $clog2(N_POINTS),
    parameter int  BF_LAT   = DEF_BF_LAT,
    localparam int SW       = stage_w(LOG2_N),
    localparam int TW       = tw_w(LOG2_N)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [SW-1:0]     stage_o,
    output logic              rd_en_o,
    output logic [LOG2_N-1:0] rd_addr_a_o,
    output logic [LOG2_N-1:0] rd_addr_b_o,
    output logic [TW-1:0]     tw_idx_o,
    output logic              wr_en_o,
    output logic [LOG2_N-1:0] wr_addr_a_o,
    output logic [LOG2_N-1:0] wr_addr_b_o,
    output logic              out_rd_en_o,
    output logic [LOG2_N-1:0] out_addr_o,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast
);

    localparam int                DW     = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam logic [LOG2_N-2:0] K_LAST = '1;
    localparam logic [SW-1:0]     S_LAST = SW'(LOG2_N - 1);
    localparam logic [DW-1:0]     D_LAST = DW'(BF_LAT - 1);
    localparam logic [LOG2_N-1:0] B_LAST = '1;

    fft_state_e        state;
    logic [SW-1:0]     s;
    logic [LOG2_N-2:0] k;
    logic [DW-1:0]     dcnt;
    logic [LOG2_N:0]   rd_b;
    logic [LOG2_N-1:0] hs_b;
    logic              tvalid_q;
    logic              hs;

    logic [LOG2_N-1:0] gen_a, gen_b;
    logic [TW-1:0]     gen_tw;

    logic [BF_LAT:1]                   vld_pipe;
    logic [BF_LAT:1][LOG2_N-1:0]       a_pipe, b_pipe;

    fft_addr_gen #(.LOG2_N(LOG2_N)) u_addr_gen (
        .stage  (s),
        .k      (k),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    // Address outputs are gated so the bus reads zero whenever no strobe is up.
    assign rd_en_o     = (state == RUN);
    assign rd_addr_a_o = rd_en_o ? gen_a : '0;
    assign rd_addr_b_o = rd_en_o ? gen_b : '0;
    assign tw_idx_o    = rd_en_o ? gen_tw : '0;
    assign stage_o     = (state == RUN || state == DRAIN) ? s : '0;
    assign busy_o      = (state != IDLE);

    assign wr_en_o     = vld_pipe[BF_LAT];
    assign wr_addr_a_o = a_pipe[BF_LAT];
    assign wr_addr_b_o = b_pipe[BF_LAT];

    // A new read may be issued when the output register is empty or draining this cycle.
    assign out_rd_en_o = (state == OUT) && !rd_b[LOG2_N] && (!tvalid_q || m_tready);
    assign out_addr_o  = out_rd_en_o ? LOG2_N'(bitrev(32'(rd_b[LOG2_N-1:0]), LOG2_N)) : '0;
    assign m_tvalid    = tvalid_q;
    assign m_tlast     = tvalid_q && (hs_b == B_LAST);
    assign hs          = tvalid_q && m_tready;
    assign done_o      = m_tlast && m_tready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
            a_pipe   <= '0;
            b_pipe   <= '0;
        end else begin
            vld_pipe[1] <= rd_en_o;
            a_pipe[1]   <= rd_addr_a_o;
            b_pipe[1]   <= rd_addr_b_o;
            for (int i = 2; i <= BF_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                a_pipe[i]   <= a_pipe[i-1];
                b_pipe[i]   <= b_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            s        <= '0;
            k        <= '0;
            dcnt     <= '0;
            rd_b     <= '0;
            hs_b     <= '0;
            tvalid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= RUN;
                        s     <= '0;
                        k     <= '0;
                    end
                end
                RUN: begin
                    if (k == K_LAST) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end else begin
                        k <= k + (LOG2_N-1)'(1);
                    end
                end
                // BF_LAT idle read cycles let every write-back of this stage
                // land before the next stage reads the same locations.
                DRAIN: begin
                    if (dcnt == D_LAST) begin
                        if (s == S_LAST) begin
                            state <= OUT;
                            s     <= '0;
                            rd_b  <= '0;
                            hs_b  <= '0;
                        end else begin
                            state <= RUN;
                            s     <= s + SW'(1);
                            k     <= '0;
                        end
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                OUT: begin
                    if (out_rd_en_o) begin
                        rd_b     <= rd_b + (LOG2_N+1)'(1);
                        tvalid_q <= 1'b1;
                    end else if (m_tready) begin
                        tvalid_q <= 1'b0;
                    end
                    if (hs) begin
                        if (hs_b == B_LAST) begin
                            state <= IDLE;
                            hs_b  <= '0;
                            rd_b  <= '0;
                        end else begin
                            hs_b <= hs_b + LOG2_N'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed + randomized bench for fft_stage_sequencer across three size/latency configurations.
module tb_fft_stage_sequencer;

    localparam int NG = 3;
    localparam int NP_TAB [NG] = '{8, 16, 4};
    localparam int BL_TAB [NG] = '{2, 1, 3};

    logic clk = 1'b0;
    logic rst_n;
    logic [NG-1:0] start, tready;
    logic [NG-1:0] busy_v, done_v, rde_v, wre_v, ore_v, tv_v, tl_v, any_out;
    logic [NG-1:0][3:0] rd_a, rd_b, tw_v, wr_a, wr_b, oa_v;
    logic [NG-1:0][1:0] stg_v;
    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NG; g++) begin : g_dut
        localparam int NP = NP_TAB[g];
        localparam int LG = $clog2(NP);
        localparam int SW = (LG > 1) ? $clog2(LG) : 1;
        logic busy, done, rde, wre, ore, tv, tl;
        logic [SW-1:0] st;
        logic [LG-1:0] ra, rb, wa, wb, oa;
        logic [LG-2:0] tw;

        fft_stage_sequencer #(.N_POINTS(NP), .BF_LAT(BL_TAB[g])) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .start_i     (start[g]),
            .busy_o      (busy),
            .done_o      (done),
            .stage_o     (st),
            .rd_en_o     (rde),
            .rd_addr_a_o (ra),
            .rd_addr_b_o (rb),
            .tw_idx_o    (tw),
            .wr_en_o     (wre),
            .wr_addr_a_o (wa),
            .wr_addr_b_o (wb),
            .out_rd_en_o (ore),
            .out_addr_o  (oa),
            .m_tvalid    (tv),
            .m_tready    (tready[g]),
            .m_tlast     (tl)
        );

        assign busy_v[g] = busy;
        assign done_v[g] = done;
        assign rde_v[g]  = rde;
        assign wre_v[g]  = wre;
        assign ore_v[g]  = ore;
        assign tv_v[g]   = tv;
        assign tl_v[g]   = tl;
        assign rd_a[g]   = 4'(ra);
        assign rd_b[g]   = 4'(rb);
        assign tw_v[g]   = 4'(tw);
        assign wr_a[g]   = 4'(wa);
        assign wr_b[g]   = 4'(wb);
        assign oa_v[g]   = 4'(oa);
        assign stg_v[g]  = 2'(st);
        assign any_out[g] = busy | done | (|st) | rde | (|ra) | (|rb) | (|tw) | wre
                          | (|wa) | (|wb) | ore | (|oa) | tv | tl;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int brev(input int v, input int w);
        int r = 0;
        for (int i = 0; i < w; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    // rmode: 0 = always ready, 1 = 3-cycle stall at beat 2 then alternating, 2 = random.
    // spur: pulse start_i at random while busy and always on the last beat.
    task automatic run_fft(input int g, input int rmode, input bit spur);
        int np, bl, lg, hs, p, idx;
        bit fin, ptv, ptr;
        int rc[$], ra[$], rb[$], rt[$], rs[$], wc[$], wa[$], wb[$];
        int oc[$], oa[$], pend[$], ha[$];
        np = NP_TAB[g]; bl = BL_TAB[g]; lg = $clog2(np);
        hs = 0; p = 0; fin = 0; ptv = 0; ptr = 0;
        start[g] = 1'b1;
        @(posedge clk); #1;
        start[g] = 1'b0;
        chk("busy_on_accept", busy_v[g], 1);
        for (int c = 0; c < 1000 && !fin; c++) begin
            case (rmode)
                0: tready[g] = 1'b1;
                1: if (hs < 2) tready[g] = 1'b1;
                   else begin tready[g] = (p >= 3) && ((p - 3) % 2 == 0); p++; end
                default: tready[g] = 1'($urandom_range(0, 1));
            endcase
            if (spur && busy_v[g] && (tl_v[g] || $urandom_range(0, 3) == 0)) begin
                start[g] = 1'b1;
                if (tl_v[g]) tready[g] = 1'b1;
            end
            @(negedge clk);
            if (rde_v[g]) begin
                rc.push_back(c); ra.push_back(int'(rd_a[g])); rb.push_back(int'(rd_b[g]));
                rt.push_back(int'(tw_v[g])); rs.push_back(int'(stg_v[g]));
            end
            if (wre_v[g]) begin
                wc.push_back(c); wa.push_back(int'(wr_a[g])); wb.push_back(int'(wr_b[g]));
            end
            if (ptv && !ptr) chk("tvalid_hold", tv_v[g], 1);
            if (tv_v[g] && tready[g]) begin
                chk("tlast", tl_v[g], hs == np - 1);
                chk("done", done_v[g], hs == np - 1);
                if (pend.size() > 0) ha.push_back(pend.pop_front());
                hs++;
                fin = (hs == np);
            end else if (done_v[g]) begin
                chk("done_without_handshake", done_v[g], 0);
            end
            if (ore_v[g]) begin
                oc.push_back(c); oa.push_back(int'(oa_v[g])); pend.push_back(int'(oa_v[g]));
            end
            ptv = tv_v[g]; ptr = tready[g];
            @(posedge clk); #1;
            start[g] = 1'b0;
        end
        chk("run_finished", fin, 1);
        chk("busy_after_done", busy_v[g], 0);
        tready[g] = 1'b0;

        chk("rd_count", ra.size(), lg * np / 2);
        chk("wr_count", wc.size(), lg * np / 2);
        idx = 0;
        for (int s = 0; s < lg; s++) begin
            int span = np >> (s + 1);
            for (int grp = 0; grp < np / (2 * span); grp++) begin
                for (int j = 0; j < span; j++) begin
                    if (idx < ra.size()) begin
                        chk("rd_addr_a", ra[idx], grp * 2 * span + j);
                        chk("rd_addr_b", rb[idx], grp * 2 * span + j + span);
                        chk("tw_idx", rt[idx], j << s);
                        chk("stage", rs[idx], s);
                        chk("rd_cycle", rc[idx], idx + s * bl);
                    end
                    if (idx < wc.size() && idx < rc.size()) begin
                        chk("wr_cycle", wc[idx], rc[idx] + bl);
                        chk("wr_addr_a", wa[idx], grp * 2 * span + j);
                        chk("wr_addr_b", wb[idx], grp * 2 * span + j + span);
                    end
                    idx++;
                end
            end
        end
        if (rc.size() > 0 && wc.size() > 0)
            chk("compute_cycles", wc[$] + 1 - rc[0], lg * (np / 2 + bl));

        chk("out_reads", oa.size(), np);
        chk("handshakes", ha.size(), np);
        if (oc.size() > 0) chk("out_start", oc[0], lg * (np / 2 + bl));
        for (int i = 0; i < np; i++) begin
            if (i < oa.size()) chk("out_addr", oa[i], brev(i, lg));
            if (i < ha.size()) chk("beat_addr", ha[i], brev(i, lg));
            if (rmode == 0 && i < oc.size()) chk("out_cycle", oc[i], lg * (np / 2 + bl) + i);
        end
    endtask

    // Abort during stage 1, k=2 (the only read with addr_a=4 in that stage for N=8).
    task automatic reset_mid(input int g);
        bit hit = 0;
        start[g] = 1'b1;
        @(posedge clk); #1;
        start[g] = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (stg_v[g] == 2'd1 && rde_v[g] && rd_a[g] == 4'd4) hit = 1;
            else begin @(posedge clk); #1; end
        end
        chk("reset_point_reached", hit, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_outs_async", any_out[g], 0);
        @(posedge clk); #1;
        chk("reset_outs_held", any_out[g], 0);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_reset_no_write", wre_v[g], 0);
            chk("post_reset_idle", any_out[g], 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = '0;
        tready = '0;
        #3;
        for (int g = 0; g < NG; g++) chk("reset_outs", any_out[g], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NG; g++) chk("post_release_outs", any_out[g], 0);
        @(posedge clk); #1;

        run_fft(0, 0, 0);
        run_fft(0, 1, 0);
        reset_mid(0);
        run_fft(0, 0, 0);
        run_fft(0, 2, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("idle_after_spurious", busy_v[0], 0);
            @(posedge clk); #1;
        end
        run_fft(0, 2, 0);
        run_fft(1, 0, 0);
        run_fft(1, 2, 0);
        run_fft(2, 0, 0);
        run_fft(2, 2, 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
Control block for the in-place radix-2 DIF FFT held in the dual-port frame memory.
- Triggered by start_i once the input frame is fully loaded.
- Walks LOG2_N butterfly stages: generates paired read/write addresses, twiddle indices and write enables for the butterfly datapath.
- Then streams the result out of memory in bit-reversed (natural-frequency) order on an AXI-stream-style master handshake.
- Sits between the frame-load logic and the butterfly/output datapath.

Parameters:
- N_POINTS, 8: FFT size. Power of two, ≥4.
- LOG2_N, $clog2(N_POINTS): address width and number of stages.
- BF_LAT, 2: cycles from rd_en_o (read issue) to the corresponding write-back. ≥1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  pulse: frame loaded, begin transform.
- busy_o  out  1  high from the start-accept cycle until done_o.
- done_o  out  1  one-cycle pulse on the final output handshake.
- stage_o  out  $clog2(LOG2_N)  current stage index (0 outside compute).
- rd_en_o  out  1  butterfly read strobe, port A and port B.
- rd_addr_a_o  out  LOG2_N  butterfly upper-leg address.
- rd_addr_b_o  out  LOG2_N  butterfly lower-leg address.
- tw_idx_o  out  LOG2_N-1  twiddle ROM index, aligned with rd_en_o.
- wr_en_o  out  1  butterfly write-back strobe.
- wr_addr_a_o  out  LOG2_N  write-back address, upper leg.
- wr_addr_b_o  out  LOG2_N  write-back address, lower leg.
- out_rd_en_o  out  1  output-phase memory read strobe (port A).
- out_addr_o  out  LOG2_N  output-phase read address.
- m_tvalid  out  1  output beat valid. Memory data is presented 1 cycle after out_rd_en_o.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  high with beat N_POINTS-1.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, all counters 0, write delay line cleared.
  - Every output is 0 during reset and in the cycle after release.
  - Reset mid-operation aborts immediately. No pending write may be issued after release.
- States: IDLE, RUN, DRAIN, OUT.
- IDLE:
  - start_i=1 → RUN in the next cycle; stage=0, k=0, busy_o=1.
  - start_i in any other state is ignored.
- RUN: one butterfly per cycle, k=0..N/2-1, rd_en_o=1. With span = N>>(s+1), group = k/span, j = k%span:
  - addr_a = group·2·span + j
  - addr_b = addr_a + span
  - tw_idx = j<<s
  - After k=N/2-1 → DRAIN.
- Write-back path:
  - {addr_a, addr_b, valid} passes through a BF_LAT-deep shift register.
  - wr_en_o/wr_addr_*_o are exactly rd_en_o/rd_addr_*_o delayed by BF_LAT cycles.
- DRAIN:
  - Wait until the delay line is empty, i.e. BF_LAT cycles with no rd_en_o.
  - Guarantees no read-after-write hazard on the in-place buffer.
  - Then: if s<LOG2_N-1, increment s, k=0 → RUN; else → OUT.
  - Compute time is exactly LOG2_N·(N/2+BF_LAT) cycles from the first rd_en_o to the cycle after the last wr_en_o.
- OUT:
  - Beat counter b=0..N-1; out_addr_o = bitrev(b).
  - out_rd_en_o asserts when (!m_tvalid || m_tready) and unread beats remain.
  - m_tvalid is set the cycle after a read. It holds while m_tready=0, and out_rd_en_o stays low while stalled.
  - Back-to-back reads sustain one beat per cycle under continuous m_tready.
  - m_tlast = m_tvalid && beat==N-1.
  - Handshake on the last beat: done_o=1 for one cycle, busy_o=0, → IDLE.
- Simultaneous events:
  - start_i coinciding with done_o is ignored. The next start must come in IDLE.
  - m_tready toggling every cycle must not drop or duplicate a beat.
- stage_o holds s in RUN/DRAIN and is 0 elsewhere.

Decomposition:
- Shared fft_pkg holds:
  - state enum typedef
  - bitrev function (width-generic)
  - localparams for stage-counter and twiddle-index widths
- Sub-module fft_addr_gen: combinational (stage, k) → {addr_a, addr_b, tw_idx}. It is reused by the verification model.
- Sequencer FSM, write delay line and output handshake stay in fft_stage_sequencer.

Test Plan:
1. Basic run (N=8, BF_LAT=2): start pulse → rd pairs and tw_idx in this order, then DRAIN → OUT. wr_* match rd_* delayed 2 cycles. 18 compute cycles.
   - Stage 0: (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3
   - Stage 1: (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2
   - Stage 2: (0,1)(2,3)(4,5)(6,7), tw 0
2. Output order: m_tready=1 constantly → out_addr sequence 0,4,2,6,1,5,3,7 on consecutive cycles. m_tlast on the 8th beat, done_o pulse the same cycle, busy_o low the next cycle.
3. Backpressure: m_tready low for 3 cycles at beat 2, then alternating 1/0 → exactly 8 handshakes, no duplicate or missing address, m_tvalid never drops while m_tready=0.
4. Reset mid-RUN: rst_ni low during stage 1, k=2 → all outputs 0 immediately. No wr_en_o after release; a fresh start reproduces scenario 1 exactly.
5. Spurious start: start_i pulsed during RUN, DRAIN and OUT, and on the done_o cycle → ignored, sequence unchanged. A start in IDLE afterwards begins a new run.
6. Parameter sweep: N=16, BF_LAT=1 and N=4, BF_LAT=3 → addresses match the fft_addr_gen formula. Compute cycles 4·(8+1)=36 and 2·(2+3)=10 respectively.
